// File: rtl/debounce_button.sv
// debounce_button: debounces one push-button using a slow toggling strobe
// (both strobe edges are sample points) and emits a clean level plus
// one-cycle press/release pulses in the clk_in domain.
// Ports:
//   clk_in        system clock, rising edge
//   reset         asynchronous active-low reset
//   tick_in       slow toggling sample strobe (asynchronous, synced here)
//   btn_raw       raw active-high button pin (asynchronous, bouncing)
//   btn_out       debounced level
//   press_pulse   one cycle high on accepted 0->1
//   release_pulse one cycle high on accepted 1->0
//   long_press    one cycle high after LONG_SAMPLES held samples
// Optional feature macro: DEBOUNCE_LONGPRESS_EN enables the long-press
// detector; without it long_press is tied low.
module debounce_button #(
    parameter int STABLE_SAMPLES = 4,
    parameter int LONG_SAMPLES   = 100
) (
    input  logic clk_in,
    input  logic reset,
    input  logic tick_in,
    input  logic btn_raw,
    output logic btn_out,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    typedef enum logic [1:0] {
        IDLE_LOW,
        CHK_HIGH,
        IDLE_HIGH,
        CHK_LOW
    } state_t;

    localparam logic [7:0] STABLE_N = 8'(STABLE_SAMPLES);

    logic       btn_meta;
    logic       btn_s;
    logic       tick_meta;
    logic       tick_s;
    logic       tick_d;
    logic       sample_en;
    state_t     state;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    logic       press_hit;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            btn_meta  <= 1'b0;
            btn_s     <= 1'b0;
            tick_meta <= 1'b0;
            tick_s    <= 1'b0;
            tick_d    <= 1'b0;
        end else begin
            btn_meta  <= btn_raw;
            btn_s     <= btn_meta;
            tick_meta <= tick_in;
            tick_s    <= tick_meta;
            tick_d    <= tick_s;
        end
    end

    // Either edge of the strobe is a sample point.
    assign sample_en = tick_s ^ tick_d;
    assign cnt_inc   = cnt + 8'd1;
    assign press_hit = sample_en & btn_s
                     & (state == CHK_HIGH)
                     & (cnt_inc == STABLE_N);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state         <= IDLE_LOW;
            cnt           <= 8'd0;
            btn_out       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (sample_en) begin
                unique case (state)
                    IDLE_LOW: begin
                        if (btn_s) begin
                            state <= CHK_HIGH;
                            cnt   <= 8'd1;
                        end
                    end
                    CHK_HIGH: begin
                        if (!btn_s) begin
                            state <= IDLE_LOW;
                            cnt   <= 8'd0;
                        end else if (cnt_inc == STABLE_N) begin
                            state       <= IDLE_HIGH;
                            cnt         <= 8'd0;
                            btn_out     <= 1'b1;
                            press_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    IDLE_HIGH: begin
                        if (!btn_s) begin
                            state <= CHK_LOW;
                            cnt   <= 8'd1;
                        end
                    end
                    CHK_LOW: begin
                        if (btn_s) begin
                            state <= IDLE_HIGH;
                            cnt   <= 8'd0;
                        end else if (cnt_inc == STABLE_N) begin
                            state         <= IDLE_LOW;
                            cnt           <= 8'd0;
                            btn_out       <= 1'b0;
                            release_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        state <= IDLE_LOW;
                        cnt   <= 8'd0;
                    end
                endcase
            end
        end
    end

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam logic [15:0] LONG_N = 16'(LONG_SAMPLES);

    logic [15:0] hold_cnt;
    logic [15:0] hold_inc;
    logic        hold_step;

    // The counter is only cleared by a fresh press, so a release bounce
    // that falls back to IDLE_HIGH cannot re-arm the detector.
    assign hold_inc  = hold_cnt + 16'd1;
    assign hold_step = sample_en & btn_s
                     & (state == IDLE_HIGH)
                     & (hold_cnt != LONG_N);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            hold_cnt   <= 16'd0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (press_hit) begin
                hold_cnt <= 16'd0;
            end else if (hold_step) begin
                hold_cnt   <= hold_inc;
                long_press <= (hold_inc == LONG_N);
            end
        end
    end
`else
    logic [15:0] unused_long;

    assign unused_long = 16'(LONG_SAMPLES);
    assign long_press  = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_button.sv
// tb_debounce_button: table-driven check of debounce_button with a
// bench-driven sample strobe, plus reset and stuck-strobe sequences.
module tb_debounce_button;

    localparam int STABLE = 4;
    localparam int LONG   = 8;
`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int LP = 1;
`else
    localparam int LP = 0;
`endif

    logic clk_in;
    logic reset;
    logic tick_in;
    logic btn_raw;
    logic btn_out;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    int checks   = 0;
    int failures = 0;
    int n_press  = 0;
    int n_rel    = 0;
    int n_long   = 0;
    int n_wide   = 0;
    int n_both   = 0;
    logic prev_p = 1'b0;
    logic prev_r = 1'b0;
    logic prev_l = 1'b0;

    typedef struct {
        logic btn;
        logic out;
        int   p;
        int   r;
        int   l;
    } vec_t;

    vec_t vecs[$];

    debounce_button #(
        .STABLE_SAMPLES(STABLE),
        .LONG_SAMPLES  (LONG)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .tick_in      (tick_in),
        .btn_raw      (btn_raw),
        .btn_out      (btn_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Pulse monitor: counts pulses and flags wide or overlapping ones.
    always @(negedge clk_in) begin
        if (press_pulse === 1'b1) n_press <= n_press + 1;
        if (release_pulse === 1'b1) n_rel <= n_rel + 1;
        if (long_press === 1'b1) n_long <= n_long + 1;
        if ((press_pulse & prev_p) === 1'b1) n_wide <= n_wide + 1;
        if ((release_pulse & prev_r) === 1'b1) n_wide <= n_wide + 1;
        if ((long_press & prev_l) === 1'b1) n_wide <= n_wide + 1;
        if ((press_pulse & release_pulse) === 1'b1) n_both <= n_both + 1;
        prev_p <= press_pulse;
        prev_r <= release_pulse;
        prev_l <= long_press;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic eo,
                             input int ep, input int er, input int el);
        check({tag, " btn_out"}, 32'(btn_out), 32'(eo));
        check({tag, " press_cnt"}, n_press, ep);
        check({tag, " release_cnt"}, n_rel, er);
        check({tag, " long_cnt"}, n_long, el);
    endtask

    // One sample: settle btn, toggle the strobe, let the FSM respond.
    task automatic step(input logic b);
        @(negedge clk_in);
        btn_raw = b;
        repeat (10) @(negedge clk_in);
        tick_in = ~tick_in;
        repeat (5) @(negedge clk_in);
        #1;
    endtask

    task automatic hold_reset(input string tag, input int n);
        @(negedge clk_in);
        reset = 1'b0;
        #1;
        check({tag, " async"}, 32'(btn_out), 32'd0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            check(tag, {28'd0, btn_out, press_pulse,
                        release_pulse, long_press}, 32'd0);
        end
        tick_in = 1'b0;
        @(negedge clk_in);
        reset = 1'b1;
    endtask

    function automatic void add(input logic b, input logic o,
                                input int p, input int r,
                                input int l);
        vec_t v;
        v.btn = b;
        v.out = o;
        v.p   = p;
        v.r   = r;
        v.l   = l;
        vecs.push_back(v);
    endfunction

    initial begin
        reset   = 1'b0;
        tick_in = 1'b0;
        btn_raw = 1'b1;

        // Held press through reset, then accepted after release.
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0);
        for (int i = 0; i < 7; i++) add(1, 1, 1, 0, 0);
        add(1, 1, 1, 0, LP);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 0, LP);
        add(0, 0, 1, 1, LP);
        // Bounce: 3 high, 1 low, 4 high.
        for (int i = 0; i < 3; i++) add(1, 0, 1, 1, LP);
        add(0, 0, 1, 1, LP);
        for (int i = 0; i < 3; i++) add(1, 0, 1, 1, LP);
        add(1, 1, 2, 1, LP);
        for (int i = 0; i < 7; i++) add(1, 1, 2, 1, LP);
        add(1, 1, 2, 1, 2 * LP);
        for (int i = 0; i < 50; i++) add(1, 1, 2, 1, 2 * LP);
        // Release bounce: 2 low, 1 high, 4 low.
        for (int i = 0; i < 2; i++) add(0, 1, 2, 1, 2 * LP);
        add(1, 1, 2, 1, 2 * LP);
        for (int i = 0; i < 3; i++) add(0, 1, 2, 1, 2 * LP);
        add(0, 0, 2, 2, 2 * LP);

        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            check("reset_hold", {28'd0, btn_out, press_pulse,
                                 release_pulse, long_press}, 32'd0);
        end
        @(negedge clk_in);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].btn);
            check_all($sformatf("row%0d", i), vecs[i].out,
                      vecs[i].p, vecs[i].r, vecs[i].l);
        end

        // Reset in CHK_HIGH with cnt=2.
        step(1);
        step(1);
        check_all("chk_high_pre", 0, 2, 2, 2 * LP);
        hold_reset("rst_chk_high", 20);
        check_all("rst_chk_high_post", 0, 2, 2, 2 * LP);
        btn_raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_all("fresh_count", 0, 2, 2, 2 * LP);
        end
        step(1);
        check_all("fresh_press", 1, 3, 2, 2 * LP);

        // Reset in CHK_LOW while btn_out=1.
        step(0);
        step(0);
        check_all("chk_low_pre", 1, 3, 2, 2 * LP);
        hold_reset("rst_chk_low", 20);
        check_all("rst_chk_low_post", 0, 3, 2, 2 * LP);
        for (int i = 0; i < 3; i++) step(1);
        step(1);
        check_all("repress", 1, 4, 2, 2 * LP);

        // Strobe frozen: button noise must not move anything.
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk_in);
                btn_raw = 1'(($urandom_range(0, 1)));
                if (btn_out !== 1'b1) bad++;
            end
            check("stuck_tick errs", bad, 0);
        end
        repeat (5) @(negedge clk_in);
        #1;
        check_all("stuck_tick", 1, 4, 2, 2 * LP);

        for (int i = 0; i < 3; i++) step(0);
        check_all("late_rel_pre", 1, 4, 2, 2 * LP);
        step(0);
        check_all("late_rel", 0, 4, 3, 2 * LP);

        check("pulse_width", n_wide, 0);
        check("pulse_overlap", n_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
